// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time-of-day setting controller.
// Holds the FSM state encoding, the field limits and two small helpers.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2
  } state_e;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
    return (v == max) ? 7'd0 : v + 7'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_tick_div.sv
// Free-running one-second divider: counts 0..TICK_DIV-1 and flags the last count.
// A synchronous clear restarts the second when the user leaves set mode.
module tick_div
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CntW     = cnt_width(TICK_DIV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic [CntW-1:0] count,
  output logic            tick
);

  localparam logic [CntW-1:0] Last = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr || count_q == Last) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tick  = (count_q == Last);

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time keeper with a two-button set sequence RUN -> SET_HOUR -> SET_MIN -> RUN.
// Time advances on the divider tick only in RUN; the selected field blinks while setting.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       inc_btn,
  output logic [6:0] hour,
  output logic [6:0] minute,
  output logic [6:0] second,
  output logic       setting,
  output logic       sel_hour,
  output logic       sel_min,
  output logic       blink,
  output logic       sec_tick
);

  localparam int unsigned     CntW = cnt_width(TICK_DIV);
  localparam logic [CntW-1:0] Half = CntW'(TICK_DIV / 2);

  state_e          state_q, state_d;
  logic [6:0]      hour_q, hour_d;
  logic [6:0]      min_q, min_d;
  logic [6:0]      sec_q, sec_d;
  logic [CntW-1:0] div_count;
  logic            div_clr;

  tick_div #(
    .TICK_DIV (TICK_DIV),
    .CntW     (CntW)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .clr   (div_clr),
    .count (div_count),
    .tick  (sec_tick)
  );

  // Leaving SET_MIN restarts the second so the new time starts on a clean boundary.
  assign div_clr = (state_q == StSetMin) && set_btn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:     if (set_btn) state_d = StSetHour;
      StSetHour: if (set_btn) state_d = StSetMin;
      StSetMin:  if (set_btn) state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    setting  = (state_q != StRun);
    sel_hour = (state_q == StSetHour);
    sel_min  = (state_q == StSetMin);
    blink    = (state_q == StRun) || (div_count < Half);
  end

  // set_btn has priority over inc_btn in the set states.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    case (state_q)
      StRun: begin
        if (sec_tick) begin
          sec_d = wrap_inc(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) begin
            min_d = wrap_inc(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
              hour_d = wrap_inc(hour_q, HOUR_MAX);
            end
          end
        end
      end
      StSetHour: begin
        if (inc_btn && !set_btn) begin
          hour_d = wrap_inc(hour_q, HOUR_MAX);
        end
      end
      StSetMin: begin
        if (set_btn) begin
          sec_d = '0;
        end else if (inc_btn) begin
          min_d = wrap_inc(min_q, MIN_MAX);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
    end
  end

  assign hour   = hour_q;
  assign minute = min_q;
  assign second = sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with TICK_DIV=4: a vector table for the set
// sequence plus hand-written sequences for rollover, freezing, reset and blink.
module tb_time_set_ctrl;

  logic       clk, rst, set_btn, inc_btn;
  logic [6:0] hour, minute, second;
  logic       setting, sel_hour, sel_min, blink, sec_tick;

  int total = 0;
  int bad   = 0;

  time_set_ctrl #(
    .TICK_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_btn  (set_btn),
    .inc_btn  (inc_btn),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .setting  (setting),
    .sel_hour (sel_hour),
    .sel_min  (sel_min),
    .blink    (blink),
    .sec_tick (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic i;
    int   h;
    int   m;
    int   sec;
    logic setting;
    logic sh;
    logic sm;
    logic blink;
    logic tick;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hour"}, int'(hour), h);
    chk({name, ".minute"}, int'(minute), m);
    chk({name, ".second"}, int'(second), s);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    set_btn = 1'b0;
    inc_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock with the given buttons, sampled at the following falling edge.
  task automatic cyc(input logic s, input logic i);
    set_btn = s;
    inc_btn = i;
    @(negedge clk);
    set_btn = 1'b0;
    inc_btn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    int ticks;

    //            s     i     h  m  sec set   sh    sm    blink tick
    vecs[0]  = '{1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 2, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 2, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    do_reset();
    chk_time("reset", 0, 0, 0);
    chk("reset.setting", int'(setting), 0);
    chk("reset.sel_hour", int'(sel_hour), 0);
    chk("reset.sel_min", int'(sel_min), 0);
    chk("reset.blink", int'(blink), 1);
    chk("reset.sec_tick", int'(sec_tick), 0);

    // Vector table: set sequence, priority of set over inc, clear on exit, RUN resumes
    for (int v = 0; v < 12; v++) begin
      cyc(vecs[v].s, vecs[v].i);
      chk_time($sformatf("vec%0d", v), vecs[v].h, vecs[v].m, vecs[v].sec);
      chk($sformatf("vec%0d.setting", v), int'(setting), int'(vecs[v].setting));
      chk($sformatf("vec%0d.sel_hour", v), int'(sel_hour), int'(vecs[v].sh));
      chk($sformatf("vec%0d.sel_min", v), int'(sel_min), int'(vecs[v].sm));
      chk($sformatf("vec%0d.blink", v), int'(blink), int'(vecs[v].blink));
      chk($sformatf("vec%0d.sec_tick", v), int'(sec_tick), int'(vecs[v].tick));
    end

    // 240 cycles of RUN -> one minute, 60 ticks
    do_reset();
    ticks = 0;
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      if (sec_tick) ticks++;
    end
    chk_time("run240", 0, 1, 0);
    chk("run240.ticks", ticks, 60);

    // Preload 23:59:59 then one more tick rolls to midnight on one edge
    do_reset();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 23; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 59; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    idle(236);
    chk_time("pre_roll", 23, 59, 59);
    idle(3);
    chk_time("pre_roll_edge", 23, 59, 59);
    chk("pre_roll_edge.sec_tick", int'(sec_tick), 1);
    idle(1);
    chk_time("rollover", 0, 0, 0);

    // Set path wraps, seconds frozen while setting, set+inc exits cleanly
    do_reset();
    idle(12);
    chk_time("frz_start", 0, 0, 3);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 25; k++) cyc(1'b0, 1'b1);
    chk_time("hour_wrap", 1, 0, 3);
    idle(8);
    chk_time("hour_frozen", 1, 0, 3);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 61; k++) cyc(1'b0, 1'b1);
    chk_time("min_wrap", 1, 1, 3);
    cyc(1'b1, 1'b1);
    chk_time("exit_setmin", 1, 1, 0);
    chk("exit_setmin.setting", int'(setting), 0);
    chk("exit_setmin.blink", int'(blink), 1);
    idle(2);
    chk("exit_div.early_tick", int'(sec_tick), 0);
    idle(1);
    chk("exit_div.tick", int'(sec_tick), 1);
    idle(1);
    chk_time("exit_div.sec", 1, 1, 1);

    // set_btn in RUN on a tick edge: tick applied and SET_HOUR entered together
    do_reset();
    idle(3);
    chk("set_on_tick.pre", int'(sec_tick), 1);
    cyc(1'b1, 1'b0);
    chk_time("set_on_tick", 0, 0, 1);
    chk("set_on_tick.sel_hour", int'(sel_hour), 1);

    // Asynchronous reset mid-cycle while setting
    do_reset();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
    chk("async_pre.hour", int'(hour), 3);
    #2 rst = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst.setting", int'(setting), 0);
    chk("async_rst.sel_hour", int'(sel_hour), 0);
    chk("async_rst.blink", int'(blink), 1);
    @(negedge clk);
    rst = 1'b0;

    // Blink pattern in SET_HOUR tracks the divider; steady in RUN
    do_reset();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("blink_set%0d", k), int'(blink), (((k + 2) % 4) < 2) ? 1 : 0);
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("blink_run%0d", k), int'(blink), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
